// File: rtl/addsub_pkg.sv
// Shared types and constants for the round-robin add/sub arbiter.
package addsub_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              sub;
    } addsub_req_t;

    // On overflow the sign of A tells which rail was crossed.
    function automatic logic [DATA_W-1:0] saturate(
        input logic [DATA_W-1:0] raw,
        input logic              ovfl,
        input logic              a_sign
    );
        if (!ovfl) begin
            return raw;
        end
        return a_sign ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder/subtractor with signed-overflow flag.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        ovfl
);

    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;

    assign b_eff = b ^ {16{sub}};
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int grp = 0; grp < 4; grp++) begin
            gp[grp] = &p[4*grp +: 4];
            gg[grp] = g[4*grp+3]
                    | (p[4*grp+3] & g[4*grp+2])
                    | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                    | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
        end
    end

    // sub supplies the +1 of the two's-complement negation of B.
    always_comb begin
        logic [15:0] cvec;
        logic        carry;
        cvec  = '0;
        carry = cin | sub;
        for (int grp = 0; grp < 4; grp++) begin
            cvec[4*grp] = carry;
            for (int j = 1; j < 4; j++) begin
                cvec[4*grp+j] = g[4*grp+j-1] | (p[4*grp+j-1] & cvec[4*grp+j-1]);
            end
            carry = gg[grp] | (gp[grp] & carry);
        end
        sum  = p ^ cvec;
        ovfl = (a[15] == b_eff[15]) & (sum[15] != a[15]);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first eligible index at or after ptr, wrapping mod N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_vld
);

    always_comb begin
        logic [PTR_W:0]   pos;
        logic [PTR_W-1:0] idx;
        logic             found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            idx = pos[PTR_W-1:0];
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
        grant_vld = found;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one saturating 16-bit add/sub among NREQ requesters, round-robin,
// with a per-requester result slot under valid/ready backpressure.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_a,
    input  logic [NREQ*DATA_W-1:0]   req_b,
    input  logic [NREQ-1:0]          req_sub,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [NREQ*DATA_W-1:0]   rsp_sum,
    output logic [NREQ-1:0]          rsp_ovfl,
    output logic                     busy,
    output logic [CNT_W-1:0]         ovfl_cnt
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  rr_ptr_d, rr_ptr_q;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   fire;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              any_fire;
    addsub_req_t       req_vec [NREQ];
    addsub_req_t       sel;
    logic [DATA_W-1:0] raw_sum;
    logic [DATA_W-1:0] sat_sum;
    logic              raw_ovfl;
    logic [CNT_W-1:0]  ovfl_cnt_d, ovfl_cnt_q;

    // A full slot that is being drained this cycle can accept a refill.
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    rr_arbiter #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .elig      (elig),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign req_ready = rst ? '0 : grant;
    assign fire      = req_valid & req_ready;
    assign any_fire  = grant_vld & ~rst;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign req_vec[i] = '{a:   req_a[DATA_W*i +: DATA_W],
                              b:   req_b[DATA_W*i +: DATA_W],
                              sub: req_sub[i]};
    end

    assign sel = req_vec[grant_idx];

    cla_16bit u_cla (
        .a    (sel.a),
        .b    (sel.b),
        .sub  (sel.sub),
        .cin  (1'b0),
        .sum  (raw_sum),
        .ovfl (raw_ovfl)
    );

    assign sat_sum = saturate(raw_sum, raw_ovfl, sel.a[DATA_W-1]);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_fire) begin
            rr_ptr_d = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_comb begin
        ovfl_cnt_d = ovfl_cnt_q;
        if (any_fire && raw_ovfl && (ovfl_cnt_q != '1)) begin
            ovfl_cnt_d = ovfl_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            ovfl_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            ovfl_cnt_q <= ovfl_cnt_d;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        logic              valid_d, valid_q;
        logic              ovfl_d, ovfl_q;
        logic [DATA_W-1:0] sum_d, sum_q;

        // Data is left untouched on a pop so it reads stable until refilled.
        always_comb begin
            valid_d = valid_q;
            ovfl_d  = ovfl_q;
            sum_d   = sum_q;
            if (fire[i]) begin
                valid_d = 1'b1;
                ovfl_d  = raw_ovfl;
                sum_d   = sat_sum;
            end else if (valid_q && rsp_ready[i]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                ovfl_q  <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                ovfl_q  <= ovfl_d;
                sum_q   <= sum_d;
            end
        end

        assign rsp_valid[i]                = valid_q;
        assign rsp_ovfl[i]                 = ovfl_q;
        assign rsp_sum[DATA_W*i +: DATA_W] = sum_q;
    end

    assign busy     = |rsp_valid;
    assign ovfl_cnt = ovfl_cnt_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: op table through single requesters, then
// fairness, backpressure, counter saturation and asynchronous reset sequences.
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_sub, req_ready, rsp_valid, rsp_ready, rsp_ovfl;
    logic [63:0] req_a, req_b, rsp_sum;
    logic        busy;
    logic [3:0]  ovfl_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.NREQ(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_ovfl  (rsp_ovfl),
        .busy      (busy),
        .ovfl_cnt  (ovfl_cnt)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        ovfl;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic sub);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_sub[i]        = sub;
    endtask

    initial begin
        int         r;
        logic [3:0] oh;
        logic [3:0] exp_cnt;
        int         bp_seq [6];

        tv[0]  = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0};
        tv[1]  = '{16'h7FF0, 16'h0020, 1'b0, 16'h7FFF, 1'b1};
        tv[2]  = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1};
        tv[3]  = '{16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
        tv[4]  = '{16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0};
        tv[5]  = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0};
        tv[6]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0};
        tv[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1};
        tv[8]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1};
        tv[9]  = '{16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0};
        tv[10] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0};
        tv[11] = '{16'h2000, 16'h1000, 1'b1, 16'h1000, 1'b0};
        bp_seq = '{2, 3, 0, 2, 3, 0};

        rst       = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 4'hF;
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 4'h0);
        chk("rst_rsp_sum",   rsp_sum,   64'h0);
        chk("rst_rsp_ovfl",  rsp_ovfl,  4'h0);
        chk("rst_ovfl_cnt",  ovfl_cnt,  4'h0);
        chk("rst_busy",      busy,      1'b0);

        @(negedge clk);
        rst = 1'b0;
        #1 chk("first_grant", req_ready, 4'b0001);
        req_valid = 4'h0;

        exp_cnt = 4'h0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            r  = k % 4;
            oh = 4'b0001 << r;
            req_valid = oh;
            set_op(r, tv[k].a, tv[k].b, tv[k].sub);
            #1 chk($sformatf("vec%0d_ready", k), req_ready, oh);
            @(posedge clk);
            #1;
            if (tv[k].ovfl && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'h1;
            chk($sformatf("vec%0d_valid", k), rsp_valid[r], 1'b1);
            chk($sformatf("vec%0d_sum", k),   rsp_sum[16*r +: 16], tv[k].sum);
            chk($sformatf("vec%0d_ovfl", k),  rsp_ovfl[r], tv[k].ovfl);
            chk($sformatf("vec%0d_cnt", k),   ovfl_cnt, exp_cnt);
        end

        // Fairness: pointer is back at 0 after the op on req3.
        @(negedge clk);
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_op(i, 16'h0001, 16'h0001, 1'b0);
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("fair%0d_grant", c), req_ready, 4'b0001 << (c % 4));
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d_busy", c), busy, 1'b1);
            chk($sformatf("fair%0d_sum", c), rsp_sum[16*(c%4) +: 16], 16'h0002);
            @(negedge clk);
        end

        // Backpressure: slot1 full and not consumed.
        rsp_ready = 4'b1101;
        set_op(1, 16'h0100, 16'h0011, 1'b0);
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("bp%0d_grant", c), req_ready, 4'b0001 << bp_seq[c]);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid1", c), rsp_valid[1], 1'b1);
            chk($sformatf("bp%0d_sum1", c), rsp_sum[31:16], 16'h0002);
            @(negedge clk);
        end
        rsp_ready = 4'hF;
        #1 chk("bp_release_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("bp_reload_valid", rsp_valid[1], 1'b1);
        chk("bp_reload_sum", rsp_sum[31:16], 16'h0111);
        chk("bp_reload_ovfl", rsp_ovfl[1], 1'b0);

        // Counter saturation.
        @(negedge clk);
        req_valid = 4'b0001;
        set_op(0, 16'h7FF0, 16'h0020, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'h1;
            chk($sformatf("stick%0d_cnt", c), ovfl_cnt, exp_cnt);
        end
        chk("stick_final", ovfl_cnt, 4'hF);
        chk("stick_sum", rsp_sum[15:0], 16'h7FFF);
        chk("stick_ovfl", rsp_ovfl[0], 1'b1);

        // Asynchronous reset with pending results: they must be dropped.
        @(negedge clk);
        req_valid = 4'hF;
        rsp_ready = 4'h0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 4'h0);
        chk("mid_rst_sum",   rsp_sum,   64'h0);
        chk("mid_rst_ovfl",  rsp_ovfl,  4'h0);
        chk("mid_rst_cnt",   ovfl_cnt,  4'h0);
        chk("mid_rst_busy",  busy,      1'b0);
        chk("mid_rst_ready", req_ready, 4'h0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 4'hF;
        #1 chk("post_rst_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_valid", rsp_valid, 4'b0001);
        chk("post_rst_sum", rsp_sum[15:0], 16'h7FFF);
        chk("post_rst_cnt", ovfl_cnt, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
